// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs
//   Shared definitions for the FV bus between the FV SRAM and the Edge PEs.
//   - FV_BW      : width of one FV stream word
//   - MAX_WORDS  : maximum words per feature vector
//   - FV_SRAM2Edge_PE : one bus beat {sos, eos, FV_data}
//   - fv_state_e : capture FSM states used by fv_stream_collector
// -----------------------------------------------------------------------------
`ifndef FV_bandwidth
`define FV_bandwidth 8
`endif

package sys_defs;

  localparam int FV_BW     = `FV_bandwidth;
  localparam int MAX_WORDS = 8;

  typedef struct packed {
    logic             sos;
    logic             eos;
    logic [FV_BW-1:0] FV_data;
  } FV_SRAM2Edge_PE;

  // DROP swallows a stream that arrived while both buffers were occupied.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } fv_state_e;

endpackage

// File: rtl/fv_pingpong_buf.sv
// -----------------------------------------------------------------------------
// fv_pingpong_buf
//   Two MAX_WORDS x FV_BW register buffers with one word write port and a
//   read-select. The read port returns the *next-state* contents of the
//   selected buffer so the parent can register its output in the same cycle
//   the last word of an FV is written.
//   Ports:
//     clk, reset       clock, async active-low reset (clears all words)
//     i_wr_en          write i_wr_data to word i_wr_idx of buffer i_wr_sel
//     i_clr            zero buffer i_wr_sel (the write, if any, still lands)
//     i_wr_sel         target buffer of clear/write
//     i_wr_idx         target word
//     i_wr_data        word to write
//     i_rd_sel         buffer to read
//     o_rd_next        flattened next-state contents of buffer i_rd_sel
// -----------------------------------------------------------------------------
module fv_pingpong_buf #(
  parameter int FV_BW     = sys_defs::FV_BW,
  parameter int MAX_WORDS = sys_defs::MAX_WORDS,
  parameter int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wr_en,
  input  logic                       i_clr,
  input  logic                       i_wr_sel,
  input  logic [IDX_W-1:0]           i_wr_idx,
  input  logic [FV_BW-1:0]           i_wr_data,
  input  logic                       i_rd_sel,
  output logic [MAX_WORDS*FV_BW-1:0] o_rd_next
);

  logic [FV_BW-1:0] r_buf      [2][MAX_WORDS];
  logic [FV_BW-1:0] w_buf_next [2][MAX_WORDS];

  // Next-state of every word: write wins over clear, clear wins over hold.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (i_wr_en && (i_wr_sel == 1'(b)) && (i_wr_idx == IDX_W'(k))) begin
          w_buf_next[b][k] = i_wr_data;
        end else if (i_clr && (i_wr_sel == 1'(b))) begin
          w_buf_next[b][k] = {FV_BW{1'b0}};
        end else begin
          w_buf_next[b][k] = r_buf[b][k];
        end
      end
    end
  end

  // Flatten the selected buffer, word k at bits [k*FV_BW +: FV_BW].
  always_comb begin
    o_rd_next = {(MAX_WORDS*FV_BW){1'b0}};
    for (int k = 0; k < MAX_WORDS; k++) begin
      o_rd_next[k*FV_BW +: FV_BW] = w_buf_next[i_rd_sel][k];
    end
  end

  // Buffer storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < MAX_WORDS; k++) begin
          r_buf[b][k] <= {FV_BW{1'b0}};
        end
      end
    end else begin
      r_buf <= w_buf_next;
    end
  end

endmodule

// File: rtl/fv_stream_collector.sv
// -----------------------------------------------------------------------------
// fv_stream_collector
//   Captures FV streams from the FV bus into a ping-pong buffer pair and
//   presents complete FVs to the Edge PE with a valid/ready handshake.
//   Ports:
//     clk, reset       clock, async active-low reset
//     sos, eos         start / end of stream qualifiers
//     FV_data          stream word
//     out_valid        a complete FV is presented
//     out_ready        Edge PE accepts the presented FV
//     out_fv           presented FV, word k at [k*FV_BW +: FV_BW]
//     out_len          word count of the presented FV
//     buf_full         both buffers hold unconsumed FVs
//     err_drop         stream dropped because both buffers were full (sticky)
//     err_trunc        words beyond MAX_WORDS discarded (sticky)
//     err_proto        sos without eos, or eos without sos (sticky)
// -----------------------------------------------------------------------------
`ifndef FV_bandwidth
`define FV_bandwidth 8
`endif

module fv_stream_collector #(
  parameter int FV_BW     = `FV_bandwidth,
  parameter int MAX_WORDS = 8,
  parameter int LEN_W     = $clog2(MAX_WORDS+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sos,
  input  logic                       eos,
  input  logic [FV_BW-1:0]           FV_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAX_WORDS*FV_BW-1:0] out_fv,
  output logic [LEN_W-1:0]           out_len,
  output logic                       buf_full,
  output logic                       err_drop,
  output logic                       err_trunc,
  output logic                       err_proto
);

  import sys_defs::*;

  localparam int               IDX_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  fv_state_e                r_state;
  logic                     r_wptr;
  logic                     r_rptr;
  logic [1:0]               r_cnt;
  logic [LEN_W-1:0]         r_widx;
  logic [LEN_W-1:0]         r_len [2];
  logic                     r_out_valid;
  logic [MAX_WORDS*FV_BW-1:0] r_out_fv;
  logic [LEN_W-1:0]         r_out_len;
  logic                     r_buf_full;
  logic                     r_err_drop;
  logic                     r_err_trunc;
  logic                     r_err_proto;

  fv_state_e                w_state_next;
  logic [LEN_W-1:0]         w_widx_next;
  logic [LEN_W-1:0]         w_widx_inc;
  logic                     w_wr_en;
  logic                     w_clr;
  logic [IDX_W-1:0]         w_wr_idx;
  logic                     w_commit;
  logic [LEN_W-1:0]         w_commit_len;
  logic                     w_set_drop;
  logic                     w_set_trunc;
  logic                     w_set_proto;
  logic                     w_hs;
  logic [1:0]               w_cnt_next;
  logic                     w_wptr_next;
  logic                     w_rptr_next;
  logic [LEN_W-1:0]         w_len_next [2];
  logic                     w_valid_next;
  logic [MAX_WORDS*FV_BW-1:0] w_rd_next;

  // widx saturates at MAX_WORDS, so this is also min(widx+1, MAX_WORDS).
  assign w_widx_inc = (r_widx >= MAX_LEN) ? MAX_LEN : (r_widx + LEN_W'(1));

  // Capture FSM decode: buffer writes, commits and error events.
  always_comb begin
    w_state_next = r_state;
    w_widx_next  = r_widx;
    w_wr_en      = 1'b0;
    w_clr        = 1'b0;
    w_wr_idx     = r_widx[IDX_W-1:0];
    w_commit     = 1'b0;
    w_commit_len = w_widx_inc;
    w_set_drop   = 1'b0;
    w_set_trunc  = 1'b0;
    w_set_proto  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sos) begin
          if (r_cnt != 2'd2) begin
            // Clearing the buffer keeps words at or above out_len at zero.
            w_clr    = 1'b1;
            w_wr_en  = 1'b1;
            w_wr_idx = {IDX_W{1'b0}};
            if (eos) begin
              w_commit     = 1'b1;
              w_commit_len = LEN_W'(1);
              w_widx_next  = {LEN_W{1'b0}};
              w_state_next = ST_IDLE;
            end else begin
              w_widx_next  = LEN_W'(1);
              w_state_next = ST_RECV;
            end
          end else begin
            w_set_drop   = 1'b1;
            w_state_next = eos ? ST_IDLE : ST_DROP;
          end
        end else if (eos) begin
          w_set_proto = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (sos) begin
          // Unterminated stream: abandon it and restart in the same buffer.
          w_set_proto = 1'b1;
          w_clr       = 1'b1;
          w_wr_en     = 1'b1;
          w_wr_idx    = {IDX_W{1'b0}};
          if (eos) begin
            w_commit     = 1'b1;
            w_commit_len = LEN_W'(1);
            w_widx_next  = {LEN_W{1'b0}};
            w_state_next = ST_IDLE;
          end else begin
            w_widx_next  = LEN_W'(1);
            w_state_next = ST_RECV;
          end
        end else begin
          if (r_widx < MAX_LEN) begin
            w_wr_en = 1'b1;
          end else begin
            w_set_trunc = 1'b1;
          end
          if (eos) begin
            w_commit     = 1'b1;
            w_commit_len = w_widx_inc;
            w_widx_next  = {LEN_W{1'b0}};
            w_state_next = ST_IDLE;
          end else begin
            w_widx_next  = w_widx_inc;
            w_state_next = ST_RECV;
          end
        end
      end
      ST_DROP: begin
        if (eos) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DROP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_widx_next  = {LEN_W{1'b0}};
      end
    endcase
  end

  // Occupancy, pointers and next presented FV.
  always_comb begin
    w_hs = r_out_valid & out_ready;
    if (w_commit && !w_hs) begin
      w_cnt_next = r_cnt + 2'd1;
    end else if (!w_commit && w_hs) begin
      w_cnt_next = r_cnt - 2'd1;
    end else begin
      w_cnt_next = r_cnt;
    end
    w_wptr_next = r_wptr ^ w_commit;
    w_rptr_next = r_rptr ^ w_hs;
    w_len_next  = r_len;
    if (w_commit) begin
      w_len_next[r_wptr] = w_commit_len;
    end else begin
      w_len_next[r_wptr] = r_len[r_wptr];
    end
    w_valid_next = (w_cnt_next != 2'd0);
  end

  fv_pingpong_buf #(
    .FV_BW     (FV_BW),
    .MAX_WORDS (MAX_WORDS),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_clr     (w_clr),
    .i_wr_sel  (r_wptr),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (FV_data),
    .i_rd_sel  (w_rptr_next),
    .o_rd_next (w_rd_next)
  );

  // FSM, pointers, counters, registered outputs and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_cnt       <= 2'd0;
      r_widx      <= {LEN_W{1'b0}};
      r_len[0]    <= {LEN_W{1'b0}};
      r_len[1]    <= {LEN_W{1'b0}};
      r_out_valid <= 1'b0;
      r_out_fv    <= {(MAX_WORDS*FV_BW){1'b0}};
      r_out_len   <= {LEN_W{1'b0}};
      r_buf_full  <= 1'b0;
      r_err_drop  <= 1'b0;
      r_err_trunc <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wptr      <= w_wptr_next;
      r_rptr      <= w_rptr_next;
      r_cnt       <= w_cnt_next;
      r_widx      <= w_widx_next;
      r_len       <= w_len_next;
      r_out_valid <= w_valid_next;
      r_out_fv    <= w_valid_next ? w_rd_next : {(MAX_WORDS*FV_BW){1'b0}};
      r_out_len   <= w_valid_next ? w_len_next[w_rptr_next] : {LEN_W{1'b0}};
      r_buf_full  <= (w_cnt_next == 2'd2);
      r_err_drop  <= r_err_drop  | w_set_drop;
      r_err_trunc <= r_err_trunc | w_set_trunc;
      r_err_proto <= r_err_proto | w_set_proto;
    end
  end

  assign out_valid = r_out_valid;
  assign out_fv    = r_out_fv;
  assign out_len   = r_out_len;
  assign buf_full  = r_buf_full;
  assign err_drop  = r_err_drop;
  assign err_trunc = r_err_trunc;
  assign err_proto = r_err_proto;

endmodule

// File: tb/tb_fv_stream_collector.sv
// -----------------------------------------------------------------------------
// tb_fv_stream_collector
//   Directed-vector bench for fv_stream_collector (FV_BW=8, MAX_WORDS=8).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   at that same point, i.e. they reflect the edge that consumed the inputs.
// -----------------------------------------------------------------------------
module tb_fv_stream_collector;

  localparam int FV_BW     = 8;
  localparam int MAX_WORDS = 8;
  localparam int LEN_W     = $clog2(MAX_WORDS+1);

  logic                       clk;
  logic                       reset;
  logic                       sos;
  logic                       eos;
  logic [FV_BW-1:0]           FV_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [MAX_WORDS*FV_BW-1:0] out_fv;
  logic [LEN_W-1:0]           out_len;
  logic                       buf_full;
  logic                       err_drop;
  logic                       err_trunc;
  logic                       err_proto;

  int n_cmp;
  int n_err;

  fv_stream_collector #(
    .FV_BW     (FV_BW),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sos       (sos),
    .eos       (eos),
    .FV_data   (FV_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fv    (out_fv),
    .out_len   (out_len),
    .buf_full  (buf_full),
    .err_drop  (err_drop),
    .err_trunc (err_trunc),
    .err_proto (err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus beat; sos/eos drop back to 0 after the capturing edge.
  task automatic beat(input logic s, input logic e, input logic [7:0] d);
    sos     = s;
    eos     = e;
    FV_data = d;
    step();
    sos     = 1'b0;
    eos     = 1'b0;
    FV_data = 8'h00;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    sos       = 1'b0;
    eos       = 1'b0;
    FV_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_fv",    out_fv,    64'd0);
    chk("rst_len",   out_len,   64'd0);
    chk("rst_full",  buf_full,  64'd0);
    chk("rst_errs",  {err_drop, err_trunc, err_proto}, 64'd0);
    reset = 1'b1;
    step();

    // 3-word stream, Edge PE always ready.
    out_ready = 1'b1;
    beat(1'b1, 1'b0, 8'hA1);
    chk("s3_mid_valid", out_valid, 64'd0);
    beat(1'b0, 1'b0, 8'hA2);
    beat(1'b0, 1'b1, 8'hA3);
    chk("s3_valid", out_valid, 64'd1);
    chk("s3_len",   out_len,   64'd3);
    chk("s3_fv",    out_fv,    64'h0000_0000_00A3_A2A1);
    step();
    chk("s3_valid_1cyc", out_valid, 64'd0);

    // sos and eos together.
    beat(1'b1, 1'b1, 8'h05);
    chk("one_len", out_len, 64'd1);
    chk("one_fv",  out_fv,  64'h05);
    step();
    chk("one_consumed", out_valid, 64'd0);

    // Three back-to-back 2-word streams with Edge PE stalled.
    out_ready = 1'b0;
    beat(1'b1, 1'b0, 8'h11);
    beat(1'b0, 1'b1, 8'h12);
    chk("bb_full_after1", buf_full, 64'd0);
    beat(1'b1, 1'b0, 8'h21);
    beat(1'b0, 1'b1, 8'h22);
    chk("bb_full", buf_full, 64'd1);
    chk("bb_drop_before", err_drop, 64'd0);
    beat(1'b1, 1'b0, 8'h31);
    beat(1'b0, 1'b1, 8'h32);
    chk("bb_drop",      err_drop, 64'd1);
    chk("bb_hold_fv",   out_fv,   64'h1211);
    chk("bb_hold_len",  out_len,  64'd2);
    out_ready = 1'b1;
    step();
    chk("bb_fv2_valid", out_valid, 64'd1);
    chk("bb_fv2",       out_fv,    64'h2221);
    chk("bb_full_clr",  buf_full,  64'd0);
    step();
    chk("bb_empty", out_valid, 64'd0);
    chk("bb_no_proto", err_proto, 64'd0);

    // 10-word stream truncated to 8.
    out_ready = 1'b0;
    beat(1'b1, 1'b0, 8'h80);
    for (int i = 1; i < 9; i++) begin
      beat(1'b0, 1'b0, 8'(8'h80 + i));
    end
    beat(1'b0, 1'b1, 8'h89);
    chk("tr_len",  out_len,   64'd8);
    chk("tr_fv",   out_fv,    64'h8786_8584_8382_8180);
    chk("tr_flag", err_trunc, 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // sos, word, sos, eos: second stream only survives.
    beat(1'b1, 1'b0, 8'h41);
    beat(1'b0, 1'b0, 8'h42);
    beat(1'b1, 1'b0, 8'h51);
    beat(1'b0, 1'b1, 8'h52);
    chk("pr_flag", err_proto, 64'd1);
    chk("pr_len",  out_len,   64'd2);
    chk("pr_fv",   out_fv,    64'h5251);
    // Commit coinciding with a handshake at one buffered FV.
    beat(1'b1, 1'b0, 8'h61);
    beat(1'b0, 1'b0, 8'h62);
    out_ready = 1'b1;
    beat(1'b0, 1'b1, 8'h63);
    chk("co_valid", out_valid, 64'd1);
    chk("co_len",   out_len,   64'd3);
    chk("co_fv",    out_fv,    64'h63_6261);
    chk("co_full",  buf_full,  64'd0);
    step();
    chk("co_cnt_was_1", out_valid, 64'd0);
    out_ready = 1'b0;

    // Reset mid-RECV with one FV buffered.
    beat(1'b1, 1'b1, 8'hEE);
    beat(1'b1, 1'b0, 8'h91);
    beat(1'b0, 1'b0, 8'h92);
    chk("mr_pre_valid", out_valid, 64'd1);
    reset = 1'b0;
    #2;
    chk("mr_valid", out_valid, 64'd0);
    chk("mr_fv",    out_fv,    64'd0);
    chk("mr_len",   out_len,   64'd0);
    chk("mr_errs",  {err_drop, err_trunc, err_proto}, 64'd0);
    #2;
    reset = 1'b1;
    step();
    beat(1'b0, 1'b0, 8'hBB);
    chk("mr_ignore", out_valid, 64'd0);
    beat(1'b1, 1'b0, 8'hC1);
    beat(1'b0, 1'b1, 8'hC2);
    chk("mr_new_valid", out_valid, 64'd1);
    chk("mr_new_fv",    out_fv,    64'hC2C1);
    chk("mr_new_len",   out_len,   64'd2);
    chk("mr_new_proto", err_proto, 64'd0);
    out_ready = 1'b1;
    step();

    // eos in IDLE without sos.
    beat(1'b0, 1'b1, 8'h77);
    chk("eos_idle_proto", err_proto, 64'd1);
    chk("eos_idle_valid", out_valid, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
